// File: rtl/sd_pattern_loader.sv
// -----------------------------------------------------------------------------
// sd_pattern_loader
// Loads a Game-of-Life starting pattern from the SD card into the cell-state RAM.
// Requests NUM_BLOCKS consecutive 512-byte blocks from the SD block reader,
// starting at i_base_block, and unpacks each block LSB-first into 4096 cells,
// one cell-RAM write per clock.
//
// Optional feature macro: SD_LOADER_TIMEOUT_EN
//   defined   : a WAIT lasting TIMEOUT_CYCLES cycles aborts the load into ERROR
//               and raises the sticky o_error flag.
//   undefined : WAIT blocks indefinitely and o_error is tied to 0.
//
// Ports
//   clk_spi          in   SPI-domain clock
//   reset            in   asynchronous, active-high reset
//   i_start          in   1-cycle pulse: begin a load (ignored while busy)
//   i_base_block     in   SD block index of the first pattern block
//   o_blk_id         out  block index presented to the block reader
//   o_blk_execute    out  1-cycle pulse restarting the block reader
//   i_blk_state      in   reader state: 0=INIT, 1=READ, 2=FINISH
//   o_blk_byte_addr  out  byte index into the reader buffer
//   i_blk_byte       in   buffer byte at o_blk_byte_addr (same cycle)
//   o_cell_we        out  cell-RAM write strobe
//   o_cell_addr      out  cell index
//   o_cell_data      out  cell alive bit
//   o_busy           out  load in progress
//   o_done           out  1-cycle pulse after the last cell write
//   o_error          out  sticky wait-timeout flag
// -----------------------------------------------------------------------------
module sd_pattern_loader #(
    parameter int unsigned NUM_BLOCKS     = 4,
    parameter int unsigned CELL_AW        = 14,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk_spi,
    input  logic               reset,
    input  logic               i_start,
    input  logic [31:0]        i_base_block,
    output logic [31:0]        o_blk_id,
    output logic               o_blk_execute,
    input  logic [1:0]         i_blk_state,
    output logic [8:0]         o_blk_byte_addr,
    input  logic [7:0]         i_blk_byte,
    output logic               o_cell_we,
    output logic [CELL_AW-1:0] o_cell_addr,
    output logic               o_cell_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned BIT_W = 12;
    localparam logic [1:0]  RD_FINISH = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_UNPACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_blk_idx;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [31:0]        r_blk_id;
    logic               r_execute;
    logic               r_busy;
    logic               r_done;
    logic               r_cell_we;
    logic [CELL_AW-1:0] r_cell_addr;
    logic               r_cell_data;
    logic               w_last_bit;
    logic               w_last_blk;
    logic               w_accept;
    logic               w_timeout;
    logic               w_exec_next;
    logic               w_busy_next;
    logic               w_done_next;

    assign w_last_bit = &r_bit_cnt;
    assign w_last_blk = (r_blk_idx == IDX_W'(NUM_BLOCKS - 1));
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_ERROR)) && i_start;

`ifdef SD_LOADER_TIMEOUT_EN
    logic [31:0] r_wait_cnt;
    logic        r_error;

    // Wait counter: cleared in ARM so it starts at 0 on the first WAIT cycle.
    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ARM) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle.
    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Sticky error: set on entry to ERROR, cleared by the next accepted start.
    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if ((r_state == S_WAIT) && (w_state_next == S_ERROR)) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; FINISH takes priority over a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_ERROR: if (i_start) w_state_next = S_ISSUE;
            S_ISSUE:         w_state_next = S_ARM;
            S_ARM:           w_state_next = S_WAIT;
            S_WAIT: begin
                if (i_blk_state == RD_FINISH) begin
                    w_state_next = S_UNPACK;
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            S_UNPACK: begin
                if (w_last_bit) begin
                    w_state_next = w_last_blk ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered copies line up with r_state.
    always_comb begin
        w_exec_next = (w_state_next == S_ISSUE);
        w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_ERROR);
        w_done_next = (w_state_next == S_DONE);
    end

    // Control outputs, counters and the one-stage unpack pipeline.
    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            r_execute   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_blk_id    <= '0;
            r_blk_idx   <= '0;
            r_bit_cnt   <= '0;
            r_cell_we   <= 1'b0;
            r_cell_addr <= '0;
            r_cell_data <= 1'b0;
        end else begin
            r_execute <= w_exec_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_cell_we <= (r_state == S_UNPACK);

            if (r_state == S_UNPACK) begin
                r_cell_addr <= CELL_AW'({r_blk_idx, r_bit_cnt});
                r_cell_data <= i_blk_byte[r_bit_cnt[2:0]];
            end

            if (w_accept) begin
                r_blk_id  <= i_base_block;
                r_blk_idx <= '0;
            end else if ((r_state == S_UNPACK) && w_last_bit && !w_last_blk) begin
                // blk_id tracks base + blk_idx, wrapping at 32 bits.
                r_blk_id  <= r_blk_id + 32'd1;
                r_blk_idx <= r_blk_idx + IDX_W'(1);
            end

            if (r_state == S_WAIT) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_UNPACK) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end
    end

    assign o_blk_id        = r_blk_id;
    assign o_blk_execute   = r_execute;
    assign o_blk_byte_addr = r_bit_cnt[11:3];
    assign o_cell_we       = r_cell_we;
    assign o_cell_addr     = r_cell_addr;
    assign o_cell_data     = r_cell_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_sd_pattern_loader.sv
// -----------------------------------------------------------------------------
// tb_sd_pattern_loader
// Self-checking bench for sd_pattern_loader with NUM_BLOCKS=4. A behavioural
// SD reader answers each execute pulse after a random latency and exposes the
// block's bytes; every cell write is checked against the pattern arrays.
// Timeout checks run when SD_LOADER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sd_pattern_loader;

    localparam int unsigned NB  = 4;
    localparam int unsigned AW  = 14;
    localparam int unsigned TO  = 100;
    localparam int unsigned NCELL = NB * 4096;

    logic          clk_spi = 1'b0;
    logic          reset   = 1'b1;
    logic          i_start = 1'b0;
    logic [31:0]   i_base_block = '0;
    logic [31:0]   o_blk_id;
    logic          o_blk_execute;
    logic [1:0]    i_blk_state = 2'd0;
    logic [8:0]    o_blk_byte_addr;
    logic [7:0]    i_blk_byte;
    logic          o_cell_we;
    logic [AW-1:0] o_cell_addr;
    logic          o_cell_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    sd_pattern_loader #(
        .NUM_BLOCKS     (NB),
        .CELL_AW        (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_spi         (clk_spi),
        .reset           (reset),
        .i_start         (i_start),
        .i_base_block    (i_base_block),
        .o_blk_id        (o_blk_id),
        .o_blk_execute   (o_blk_execute),
        .i_blk_state     (i_blk_state),
        .o_blk_byte_addr (o_blk_byte_addr),
        .i_blk_byte      (i_blk_byte),
        .o_cell_we       (o_cell_we),
        .o_cell_addr     (o_cell_addr),
        .o_cell_data     (o_cell_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    always #5 clk_spi = ~clk_spi;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pattern for the current load, indexed [block][byte].
    logic [7:0]  pat [NB][512];
    logic [7:0]  buf_mem [512];
    logic [31:0] base_q = '0;
    logic        reader_hang = 1'b0;
    int unsigned load_seq = 0;

    // Monitor / reader bookkeeping (written only by the negedge process).
    int unsigned seen_seq = 0;
    int unsigned wr_cnt = 0, exec_cnt = 0, done_cnt = 0, stale_wr = 0;
    int unsigned cyc = 0, exec_cyc = 0, err_cyc = 0;
    int          rd_lat = 0;
    logic        rd_fresh = 1'b0, prev_exec = 1'b0, err_seen = 1'b0;
    logic        got8 = 1'bx, got9 = 1'bx;

    assign i_blk_byte = buf_mem[o_blk_byte_addr];

    function automatic logic exp_cell(input int unsigned a);
        logic [7:0] b;
        b = pat[(a / 4096) % NB][(a / 8) % 512];
        return b[a % 8];
    endfunction

    // Output monitor first, then the reader model advances one cycle.
    always @(negedge clk_spi) begin
        cyc++;
        if (seen_seq != load_seq) begin
            seen_seq = load_seq;
            wr_cnt = 0; exec_cnt = 0; done_cnt = 0; stale_wr = 0;
            err_seen = 1'b0; got8 = 1'bx; got9 = 1'bx;
        end
        if (!reset) begin
            if (o_cell_we) begin
                if (!rd_fresh) stale_wr++;
                check_eq("wr_addr", 64'(o_cell_addr), 64'(AW'(wr_cnt)));
                check_eq("wr_data", 64'(o_cell_data), 64'(exp_cell(wr_cnt)));
                if (o_cell_addr == AW'(8)) got8 = o_cell_data;
                if (o_cell_addr == AW'(9)) got9 = o_cell_data;
                wr_cnt++;
            end
            if (o_blk_execute) begin
                check_eq("exec_width", 64'(prev_exec), 64'(0));
                check_eq("blk_id", 64'(o_blk_id), 64'(32'(base_q + exec_cnt)));
                exec_cnt++;
                exec_cyc = cyc;
            end
            prev_exec = o_blk_execute;
            if (o_done) begin
                check_eq("done_after_last_write", 64'(wr_cnt), 64'(NCELL));
                done_cnt++;
            end
            if (o_error && !err_seen) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end

            if (o_blk_execute) begin
                i_blk_state = 2'd0;
                rd_fresh    = 1'b0;
                rd_lat      = int'($urandom_range(25, 5));
                for (int i = 0; i < 512; i++) buf_mem[i] = 8'($urandom);
            end else if (i_blk_state != 2'd2 && !reader_hang) begin
                if (rd_lat > 0) begin
                    rd_lat--;
                    i_blk_state = (rd_lat < 3) ? 2'd1 : 2'd0;
                end else begin
                    for (int i = 0; i < 512; i++)
                        buf_mem[i] = pat[(exec_cnt == 0) ? 0 : (exec_cnt - 1) % NB][i];
                    i_blk_state = 2'd2;
                    rd_fresh    = 1'b1;
                end
            end
        end
    end

    task automatic start_load(input logic [31:0] base);
        @(negedge clk_spi);
        base_q       = base;
        i_base_block = base;
        load_seq++;
        i_start = 1'b1;
        @(negedge clk_spi);
        i_start = 1'b0;
        i_base_block = 32'($urandom);
        @(negedge clk_spi);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk_spi);
        check_eq("done_seen", 64'(done_cnt), 64'(1));
    endtask

    task automatic wait_writes(input int unsigned n);
        for (int i = 0; i < 30000 && wr_cnt < n; i++) @(negedge clk_spi);
        check_eq("reach_writes", 64'(wr_cnt >= n), 64'(1));
    endtask

    task automatic check_load_end(input logic [31:0] last_id);
        repeat (3) @(negedge clk_spi);
        check_eq("write_count", 64'(wr_cnt), 64'(NCELL));
        check_eq("exec_count", 64'(exec_cnt), 64'(NB));
        check_eq("done_pulses", 64'(done_cnt), 64'(1));
        check_eq("stale_writes", 64'(stale_wr), 64'(0));
        check_eq("busy_after", 64'(o_busy), 64'(0));
        check_eq("error_after", 64'(o_error), 64'(0));
        check_eq("last_blk_id", 64'(o_blk_id), 64'(last_id));
    endtask

    initial begin
        int unsigned snap_exec, snap_wr;

        // Reset values
        for (int i = 0; i < 512; i++) buf_mem[i] = 8'h00;
        repeat (3) @(negedge clk_spi);
        check_eq("rst_cell_we", 64'(o_cell_we), 64'(0));
        check_eq("rst_cell_addr", 64'(o_cell_addr), 64'(0));
        check_eq("rst_cell_data", 64'(o_cell_data), 64'(0));
        check_eq("rst_busy", 64'(o_busy), 64'(0));
        check_eq("rst_done", 64'(o_done), 64'(0));
        check_eq("rst_error", 64'(o_error), 64'(0));
        check_eq("rst_blk_id", 64'(o_blk_id), 64'(0));
        check_eq("rst_execute", 64'(o_blk_execute), 64'(0));
        check_eq("rst_byte_addr", 64'(o_blk_byte_addr), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk_spi);

        // Load 1: block 0 holds byte k = k[7:0]
        for (int b = 0; b < int'(NB); b++)
            for (int j = 0; j < 512; j++)
                pat[b][j] = (b == 0) ? 8'(j) : 8'($urandom);
        start_load(32'h10);
        check_eq("busy_during", 64'(o_busy), 64'(1));
        wait_done(20000);
        check_load_end(32'h13);
        check_eq("cell8", 64'(got8), 64'(1));
        check_eq("cell9", 64'(got9), 64'(0));

        // Load 2: wrapping base, stale FINISH at start, start pulsed mid-unpack
        for (int b = 0; b < int'(NB); b++)
            for (int j = 0; j < 512; j++)
                pat[b][j] = 8'($urandom);
        check_eq("reader_stale", 64'(i_blk_state), 64'(2));
        start_load(32'hFFFF_FFFE);
        wait_writes(5000);
        @(negedge clk_spi);
        i_base_block = 32'h1234_5678;
        i_start = 1'b1;
        @(negedge clk_spi);
        i_start = 1'b0;
        wait_done(20000);
        check_load_end(32'h1);

        // Load 3: reset mid-unpack, then start coincident with reset
        for (int b = 0; b < int'(NB); b++)
            for (int j = 0; j < 512; j++)
                pat[b][j] = 8'($urandom);
        start_load(32'($urandom));
        wait_writes(1000);
        @(negedge clk_spi);
        reset = 1'b1;
        #1;
        check_eq("midrst_cell_we", 64'(o_cell_we), 64'(0));
        check_eq("midrst_busy", 64'(o_busy), 64'(0));
        check_eq("midrst_blk_id", 64'(o_blk_id), 64'(0));
        i_start = 1'b1;
        @(negedge clk_spi);
        i_start = 1'b0;
        @(negedge clk_spi);
        reset = 1'b0;
        snap_exec = exec_cnt;
        snap_wr   = wr_cnt;
        repeat (20) @(negedge clk_spi);
        check_eq("postrst_busy", 64'(o_busy), 64'(0));
        check_eq("postrst_exec", 64'(exec_cnt), 64'(snap_exec));
        check_eq("postrst_writes", 64'(wr_cnt), 64'(snap_wr));

`ifdef SD_LOADER_TIMEOUT_EN
        // Reader never finishes: ERROR after exactly TO wait cycles
        reader_hang = 1'b1;
        start_load(32'h20);
        for (int i = 0; i < 1000 && !err_seen; i++) @(negedge clk_spi);
        check_eq("err_seen", 64'(err_seen), 64'(1));
        check_eq("err_latency", 64'(err_cyc - exec_cyc), 64'(TO + 2));
        check_eq("err_busy", 64'(o_busy), 64'(0));
        check_eq("err_flag", 64'(o_error), 64'(1));
        check_eq("err_writes", 64'(wr_cnt), 64'(0));
        reader_hang = 1'b0;
        @(negedge clk_spi);
        i_start = 1'b1;
        @(negedge clk_spi);
        i_start = 1'b0;
        check_eq("err_cleared", 64'(o_error), 64'(0));
        check_eq("err_restart_busy", 64'(o_busy), 64'(1));
        reset = 1'b1;
        repeat (2) @(negedge clk_spi);
        reset = 1'b0;
`else
        check_eq("error_tied", 64'(o_error), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
